// File: rtl/mips_mem_pkg.sv
// Shared definitions for the unified-memory arbiter: access sizes, FSM states
// and the data-port alignment check.
package mips_mem_pkg;

    localparam logic [1:0] SZ_WORD = 2'd0;
    localparam logic [1:0] SZ_BYTE = 2'd1;
    localparam logic [1:0] SZ_HALF = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        RESP
    } arb_state_t;

    // Size 3 is handled as a word access.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] adr_lo);
        case (size)
            SZ_BYTE: return 1'b1;
            SZ_HALF: return ~adr_lo[0];
            default: return (adr_lo == 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/arb_timer.sv
// Busy-cycle counter for the memory arbiter; expired goes high in the
// TIMEOUT-th consecutive busy cycle without a memory acknowledge.
module arb_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count_reg;

    // Count holds 0 in the first busy cycle, so TIMEOUT-1 marks the last one.
    assign expired = en && (count_reg == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= '0;
        end else if (en && !expired) begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-ported memory between MIPS fetch and data ports.
// Define ARB_RR_EN for round-robin tie-break; otherwise data beats fetch.
module mem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_adr,
    output logic [DATA_W-1:0] if_inst,
    output logic              if_valid,
    output logic              if_err,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_adr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              d_err,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [1:0]        mem_size,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    arb_state_t        state_reg, state_next;
    logic [ADDR_W-1:0] adr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [1:0]        size_reg;
    logic              we_reg;
    logic              resp_d_reg;
    logic              err_reg;
    logic [DATA_W-1:0] if_inst_reg;
    logic [DATA_W-1:0] d_rdata_reg;

    logic d_req;
    logic grant_d;
    logic d_bad;
    logic busy;
    logic expired;

    assign d_req = d_read | d_write;
    assign d_bad = (d_read & d_write) | ~is_aligned(d_size, d_adr[1:0]);
    assign busy  = (state_reg == BUSY_I) || (state_reg == BUSY_D);

`ifdef ARB_RR_EN
    logic last_d_reg;

    // On a tie, the port that did not win last time gets the memory.
    assign grant_d = d_req & (~if_req | ~last_d_reg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_d_reg <= 1'b0;
        end else if (state_reg == IDLE && (d_req || if_req)) begin
            last_d_reg <= grant_d;
        end
    end
`else
    assign grant_d = d_req;
`endif

    arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (~busy),
        .en      (busy),
        .expired (expired)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (grant_d) begin
                    state_next = d_bad ? RESP : BUSY_D;
                end else if (if_req) begin
                    state_next = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ack || expired) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            adr_reg     <= '0;
            wdata_reg   <= '0;
            size_reg    <= SZ_WORD;
            we_reg      <= 1'b0;
            resp_d_reg  <= 1'b0;
            err_reg     <= 1'b0;
            if_inst_reg <= '0;
            d_rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (grant_d) begin
                        resp_d_reg <= 1'b1;
                        err_reg    <= d_bad;
                        if (d_bad) begin
                            d_rdata_reg <= '0;
                        end else begin
                            adr_reg   <= d_adr;
                            size_reg  <= d_size;
                            wdata_reg <= d_wdata;
                            we_reg    <= d_write;
                        end
                    end else if (if_req) begin
                        resp_d_reg <= 1'b0;
                        err_reg    <= 1'b0;
                        adr_reg    <= if_adr;
                        size_reg   <= SZ_WORD;
                        wdata_reg  <= '0;
                        we_reg     <= 1'b0;
                    end
                end
                BUSY_I: begin
                    if (mem_ack) begin
                        if_inst_reg <= mem_rdata;
                    end else if (expired) begin
                        if_inst_reg <= '0;
                        err_reg     <= 1'b1;
                    end
                end
                BUSY_D: begin
                    // Stores leave the last load value in place.
                    if (mem_ack) begin
                        if (!we_reg) begin
                            d_rdata_reg <= mem_rdata;
                        end
                    end else if (expired) begin
                        d_rdata_reg <= '0;
                        err_reg     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_req   = busy;
    assign mem_we    = we_reg;
    assign mem_size  = size_reg;
    assign mem_adr   = adr_reg;
    assign mem_wdata = wdata_reg;

    assign if_valid = (state_reg == RESP) && !resp_d_reg;
    assign d_valid  = (state_reg == RESP) &&  resp_d_reg;
    assign if_err   = if_valid & err_reg;
    assign d_err    = d_valid & err_reg;
    assign if_inst  = if_inst_reg;
    assign d_rdata  = d_rdata_reg;

    assign stall = (if_req & ~if_valid) | (d_req & ~d_valid);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (default TIMEOUT of 15);
// tie-break expectations follow ARB_RR_EN when it is defined.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_adr;
    logic [31:0] if_inst;
    logic        if_valid, if_err;
    logic        d_read, d_write;
    logic [1:0]  d_size;
    logic [31:0] d_adr, d_wdata, d_rdata;
    logic        d_valid, d_err, stall;
    logic        mem_req, mem_we;
    logic [1:0]  mem_size;
    logic [31:0] mem_adr, mem_wdata, mem_rdata;
    logic        mem_ack;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_adr    (if_adr),
        .if_inst   (if_inst),
        .if_valid  (if_valid),
        .if_err    (if_err),
        .d_read    (d_read),
        .d_write   (d_write),
        .d_size    (d_size),
        .d_adr     (d_adr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_valid   (d_valid),
        .d_err     (d_err),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_size  (mem_size),
        .mem_adr   (mem_adr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Two simultaneous requests: fetch at 0x20, word load at 0x10.
    task automatic run_tie(input bit data_first);
        if_req = 1'b1; if_adr = 32'h20;
        d_read = 1'b1; d_size = 2'd0; d_adr = 32'h10;
        step();
        check("tie_first_adr", mem_adr, data_first ? 32'h10 : 32'h20);
        mem_ack = 1'b1; mem_rdata = 32'hA1A1_0001;
        step();
        mem_ack = 1'b0;
        check("tie_first_dvalid", {31'd0, d_valid}, {31'd0, data_first});
        check("tie_first_ivalid", {31'd0, if_valid}, {31'd0, ~data_first});
        if (data_first) d_read = 1'b0; else if_req = 1'b0;
        step();
        step();
        check("tie_second_adr", mem_adr, data_first ? 32'h20 : 32'h10);
        mem_ack = 1'b1; mem_rdata = 32'hB2B2_0002;
        step();
        mem_ack = 1'b0;
        check("tie_second_valid", {31'd0, data_first ? if_valid : d_valid}, 32'd1);
        check("tie_second_data", data_first ? if_inst : d_rdata, 32'hB2B2_0002);
        if_req = 1'b0; d_read = 1'b0;
        step();
        $display("txn tie data_first=%0d done", data_first);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; if_req = 1'b0; if_adr = '0;
        d_read = 1'b0; d_write = 1'b0; d_size = 2'd0; d_adr = '0; d_wdata = '0;
        mem_rdata = '0; mem_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_adr", mem_adr, 32'd0);
        check("rst_valids", {30'd0, if_valid, d_valid}, 32'd0);
        check("rst_if_inst", if_inst, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        rst = 1'b0;
        $display("txn reset done");

        // Fetch with zero-wait ack.
        if_req = 1'b1; if_adr = 32'h8;
        #1 check("fetch_stall_k", {31'd0, stall}, 32'd1);
        step();
        check("fetch_mem_req", {31'd0, mem_req}, 32'd1);
        check("fetch_mem_adr", mem_adr, 32'h8);
        check("fetch_mem_we_size", {29'd0, mem_we, mem_size}, 32'd0);
        check("fetch_stall_k1", {31'd0, stall}, 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'h2400_0001;
        step();
        mem_ack = 1'b0;
        check("fetch_valid", {30'd0, if_valid, if_err}, 32'b10);
        check("fetch_inst", if_inst, 32'h2400_0001);
        check("fetch_stall_resp", {31'd0, stall}, 32'd0);
        if_req = 1'b0;
        step();
        check("fetch_idle_valid", {31'd0, if_valid}, 32'd0);
        $display("txn fetch adr=0x8 inst=0x%08h", if_inst);

        // After a fetch grant, data wins a tie in either build.
        run_tie(1'b1);

        // Misaligned half store and word load.
        d_write = 1'b1; d_size = 2'd2; d_adr = 32'h13; d_wdata = 32'h1234;
        step();
        check("mis_half_valid_err", {30'd0, d_valid, d_err}, 32'b11);
        check("mis_half_mem_req", {31'd0, mem_req}, 32'd0);
        check("mis_half_rdata", d_rdata, 32'd0);
        d_write = 1'b0;
        step();
        check("mis_half_idle", {31'd0, d_valid}, 32'd0);
        $display("txn misaligned half store adr=0x13");
        d_read = 1'b1; d_size = 2'd0; d_adr = 32'h12;
        step();
        check("mis_word_valid_err", {30'd0, d_valid, d_err}, 32'b11);
        check("mis_word_mem_req", {31'd0, mem_req}, 32'd0);
        d_read = 1'b0;
        step();
        $display("txn misaligned word load adr=0x12");

        // Byte store with one wait cycle.
        d_write = 1'b1; d_size = 2'd1; d_adr = 32'h05; d_wdata = 32'h0000_00AB;
        step();
        check("bst_mem_req_we", {30'd0, mem_req, mem_we}, 32'b11);
        check("bst_mem_size", {30'd0, mem_size}, 32'd1);
        check("bst_mem_adr", mem_adr, 32'h05);
        check("bst_wdata_lo", {24'd0, mem_wdata[7:0]}, 32'hAB);
        step();
        check("bst_wait_adr", mem_adr, 32'h05);
        check("bst_wait_valid", {31'd0, d_valid}, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
        step();
        mem_ack = 1'b0;
        check("bst_valid_err", {30'd0, d_valid, d_err}, 32'b10);
        check("bst_rdata_kept", d_rdata, 32'd0);
        d_write = 1'b0;
        step();
        $display("txn byte store adr=0x05 data=0xAB");

        // Last grant was data: round-robin now favours fetch.
`ifdef ARB_RR_EN
        run_tie(1'b0);
`else
        run_tie(1'b1);
`endif

        // Timeout on a load the memory never acknowledges.
        d_read = 1'b1; d_size = 2'd0; d_adr = 32'h40;
        step();
        n = 0;
        for (int i = 0; i < 40 && mem_req; i++) begin
            n++;
            step();
        end
        check("to_req_cycles", n, 32'd15);
        check("to_valid_err", {30'd0, d_valid, d_err}, 32'b11);
        check("to_rdata", d_rdata, 32'd0);
        d_read = 1'b0;
        step();
        $display("txn timeout load adr=0x40 busy=%0d", n);
        if_req = 1'b1; if_adr = 32'h4;
        step();
        check("to_next_adr", mem_adr, 32'h4);
        mem_ack = 1'b1; mem_rdata = 32'h3C01_0000;
        step();
        mem_ack = 1'b0;
        check("to_next_valid", {30'd0, if_valid, if_err}, 32'b10);
        check("to_next_inst", if_inst, 32'h3C01_0000);
        if_req = 1'b0;
        step();
        $display("txn fetch after timeout adr=0x4");

        // Reset while waiting on memory.
        d_read = 1'b1; d_size = 2'd0; d_adr = 32'h80;
        step();
        check("rb_mem_req", {31'd0, mem_req}, 32'd1);
        step();
        step();
        rst = 1'b1;
        #1;
        check("rb_req_drop", {31'd0, mem_req}, 32'd0);
        check("rb_no_valid", {31'd0, d_valid}, 32'd0);
        d_read = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rb_late_ack_valid", {30'd0, if_valid, d_valid}, 32'd0);
            check("rb_late_ack_req", {31'd0, mem_req}, 32'd0);
        end
        check("rb_rdata", d_rdata, 32'd0);
        mem_ack = 1'b0;
        $display("txn reset during busy");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
